// File: rtl/circle_seg_render_pkg.sv
// Purpose: shared segment bit positions and the history entry type for circle_seg_render.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: SEG_A..SEG_G bit indices in a 7-bit mask (a = LSB), hist_entry_t {valid,row,col}.
package circle_seg_render_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Column field is sized for the largest supported display count; the
   // top zero-extends its narrower display index into it.
   localparam int HIST_COL_W = 8;

   typedef struct packed {
      logic                  valid;
      logic                  row;    // 1 = top (a), 0 = bottom (d)
      logic [HIST_COL_W-1:0] col;
   } hist_entry_t;

endpackage

// File: rtl/circle_seg_render_decode.sv
// Purpose: render one history entry onto one display as a 7-bit active-high segment mask.
// Latency: combinational.
// Backpressure: none.
// Ports: row/col of the entry, disp_idx of the display being rendered, turn adds the
//        edge verticals, mask is the resulting g..a segment set.
module seg_pos_decode
   import circle_seg_render_pkg::*;
#(
   parameter int NUM_OF_DISPLAYS = 6
) (
   input  logic                  row,
   input  logic [HIST_COL_W-1:0] col,
   input  logic [HIST_COL_W-1:0] disp_idx,
   input  logic                  turn,
   output logic [6:0]            mask
);

   localparam logic [HIST_COL_W-1:0] LAST_COL = HIST_COL_W'(NUM_OF_DISPLAYS - 1);

   always_comb begin
      mask = '0;
      // An out-of-range col never equals a real display index, so such an
      // entry renders nothing without any extra check.
      if (col == disp_idx) begin
         if (row) mask[SEG_A] = 1'b1;
         else     mask[SEG_D] = 1'b1;
         if (turn && col == '0) begin
            mask[SEG_B] = 1'b1;
            mask[SEG_C] = 1'b1;
         end
         if (turn && col == LAST_COL) begin
            mask[SEG_E] = 1'b1;
            mask[SEG_F] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/circle_seg_render.sv
// Purpose: draws a moving dot with a PWM-dimmed tail on a row of seven-segment displays.
// Latency: overflow_i in T -> step_o in T+2 -> hex_o shows the new head from T+3.
// Backpressure: none; every strobe is accepted, including back-to-back strobes.
// Ports: clk_i/rst_ni clock and async active-low reset; overflow_i step strobe; row_i and
//        curr_display_i new position; hex_o registered segments; step_o capture pulse; err_o sticky range error.
module circle_seg_render
   import circle_seg_render_pkg::*;
#(
   parameter int NUM_OF_DISPLAYS = 6,
   parameter int COL_WIDTH       = $clog2(NUM_OF_DISPLAYS),
   parameter int TAIL_LEN        = 2,
   parameter int PWM_WIDTH       = 4,
   parameter int TAIL_DUTY       = 4,
   parameter int SEG_ACTIVE_LOW  = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         overflow_i,
   input  logic                         row_i,
   input  logic [COL_WIDTH-1:0]         curr_display_i,
   output logic [NUM_OF_DISPLAYS*7-1:0] hex_o,
   output logic                         step_o,
   output logic                         err_o
);

   localparam int HIST_DEPTH = TAIL_LEN + 1;
   // XOR mask that turns the active-high render into the pin polarity; it is
   // also the "all segments off" value.
   localparam logic [NUM_OF_DISPLAYS*7-1:0] HEX_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

   logic                         upd_q;
   logic [PWM_WIDTH-1:0]         pwm_cnt;
   hist_entry_t                  hist_q [HIST_DEPTH];
   hist_entry_t                  new_entry;
   logic                         tail_on;
   logic                         turn;
   logic [6:0]                   ent_mask [HIST_DEPTH][NUM_OF_DISPLAYS];
   logic [NUM_OF_DISPLAYS*7-1:0] seg_next;
   logic [NUM_OF_DISPLAYS*7-1:0] hex_q;
   logic                         step_q;
   logic                         err_q;

   // The position generator moves on the edge ending the strobe cycle, so
   // its outputs are sampled one cycle later while upd_q is high.
   assign new_entry.valid = 1'b1;
   assign new_entry.row   = row_i;
   assign new_entry.col   = HIST_COL_W'(curr_display_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         upd_q  <= 1'b0;
         step_q <= 1'b0;
         err_q  <= 1'b0;
         hist_q[0] <= '{valid: 1'b1, row: 1'b1, col: '0};
         for (int i = 1; i < HIST_DEPTH; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         upd_q  <= overflow_i;
         step_q <= upd_q;
         if (upd_q) begin
            hist_q[0] <= new_entry;
            for (int i = 1; i < HIST_DEPTH; i++) begin
               hist_q[i] <= hist_q[i-1];
            end
            if (32'(curr_display_i) >= 32'(NUM_OF_DISPLAYS)) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pwm_cnt <= '0;
      else         pwm_cnt <= pwm_cnt + 1'b1;
   end

   // 32-bit compare covers both TAIL_DUTY=0 (never) and TAIL_DUTY beyond the
   // counter range (always).
   assign tail_on = (32'(pwm_cnt) < 32'(TAIL_DUTY));

   // A vertical turn at an edge column shows up as head and entry 1 sharing
   // a display but sitting on different rows.
   generate
      if (TAIL_LEN > 0) begin : g_turn
         assign turn = hist_q[0].valid && hist_q[1].valid &&
                       (hist_q[0].col == hist_q[1].col) &&
                       (hist_q[0].row != hist_q[1].row);
      end else begin : g_no_turn
         assign turn = 1'b0;
      end
   endgenerate

   for (genvar e = 0; e < HIST_DEPTH; e++) begin : g_ent
      for (genvar d = 0; d < NUM_OF_DISPLAYS; d++) begin : g_disp
         seg_pos_decode #(
            .NUM_OF_DISPLAYS(NUM_OF_DISPLAYS)
         ) u_dec (
            .row      (hist_q[e].row),
            .col      (hist_q[e].col),
            .disp_idx (HIST_COL_W'(d)),
            .turn     ((e == 0) ? turn : 1'b0),
            .mask     (ent_mask[e][d])
         );
      end
   end

   // Head is always lit; tail entries only during the PWM on-window. Any
   // overlap simply ORs, so a segment shared with the head stays at full duty.
   always_comb begin
      seg_next = '0;
      for (int d = 0; d < NUM_OF_DISPLAYS; d++) begin
         for (int e = 0; e < HIST_DEPTH; e++) begin
            if (hist_q[e].valid && (e == 0 || tail_on)) begin
               seg_next[7*d +: 7] = seg_next[7*d +: 7] | ent_mask[e][d];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) hex_q <= HEX_OFF;
      else         hex_q <= seg_next ^ HEX_OFF;
   end

   assign hex_o  = hex_q;
   assign step_o = step_q;
   assign err_o  = err_q;

endmodule

// File: doc/circle_seg_render.md
CIRCLE_SEG_RENDER -- requirements
Module: circle_seg_render

Interface
REQ-001 Parameter NUM_OF_DISPLAYS, default 6, number of seven-segment displays; index 0 is rightmost.
REQ-002 Parameter COL_WIDTH, default $clog2(NUM_OF_DISPLAYS), width of the display index.
REQ-003 Parameter TAIL_LEN, default 2, number of past positions kept as a dimmed tail (0 = no tail).
REQ-004 Parameter PWM_WIDTH, default 4, width of the tail dimming counter.
REQ-005 Parameter TAIL_DUTY, default 4, number of PWM counts per period during which tail segments are lit.
REQ-006 Parameter SEG_ACTIVE_LOW, default 1, segment polarity on hex_o (1 = 0 lights a segment).
REQ-007 One clock; reset is asynchronous and active-low: ports clk_i and rst_ni.
REQ-008 clk_i  input  1  system clock.
REQ-009 rst_ni  input  1  asynchronous active-low reset.
REQ-010 overflow_i  input  1  step strobe; the position generator updates its outputs on the edge that ends this cycle.
REQ-011 row_i  input  1  lit row of the new position: 1 top (segment a), 0 bottom (segment d).
REQ-012 curr_display_i  input  COL_WIDTH  display index of the new position.
REQ-013 hex_o  output  NUM_OF_DISPLAYS*7  registered segments; display k occupies bits [7k+6:7k], bit order g,f,e,d,c,b,a (a = LSB).
REQ-014 step_o  output  1  one-cycle pulse when a new head position enters the history.
REQ-015 err_o  output  1  sticky flag: a captured curr_display_i was >= NUM_OF_DISPLAYS.

Function
REQ-016 overflow_i SHALL be registered into upd_q; row_i/curr_display_i SHALL be sampled in the cycle upd_q is high (generator outputs already settled).
REQ-017 History SHALL be a shift register of 1+TAIL_LEN entries {valid,row,col}; on capture, entry 0 (head) takes the sample, entry i takes entry i-1.
REQ-018 Back-to-back overflow_i in consecutive cycles SHALL produce one shift per strobe; no strobe is dropped.
REQ-019 Head segments SHALL be lit always; tail entries SHALL be lit only while pwm_cnt < TAIL_DUTY.
REQ-020 pwm_cnt SHALL free-run 0..2^PWM_WIDTH-1 and wrap to 0; TAIL_DUTY=0 means tail never lit, TAIL_DUTY>=2^PWM_WIDTH means always lit.
REQ-021 Entry with row=1 SHALL light segment a of display col; row=0 SHALL light segment d.
REQ-022 Turn rendering: when head and entry 1 are valid, share col, and differ in row, the head display SHALL additionally light b and c if col=0, or e and f if col=NUM_OF_DISPLAYS-1; no verticals at any other col.
REQ-023 Contributions SHALL be OR-combined per segment; overlapping head/tail lights the segment at full duty.
REQ-024 An entry with col >= NUM_OF_DISPLAYS SHALL be stored but render nothing; its capture SHALL set err_o.
REQ-025 Latency: overflow_i high in cycle T -> step_o high in cycle T+2 -> hex_o shows the new head from cycle T+3.
REQ-026 hex_o SHALL be fully registered; polarity is applied in the output register per SEG_ACTIVE_LOW.

Reset
REQ-027 On rst_ni low: upd_q=0, pwm_cnt=0, step_o=0, err_o=0, all hex_o segments off.
REQ-028 On rst_ni low: head = {valid=1,row=1,col=0}, all tail entries invalid; this matches the generator reset position.
REQ-029 Reset asserted mid-operation SHALL clear history and err_o immediately, regardless of a pending upd_q.
REQ-030 First clock edge after reset release SHALL load hex_o with the reset head (display 0, segment a).

Structure
REQ-031 Shared package SHALL hold the segment bit constants (SEG_A..SEG_G) and the history entry packed typedef.
REQ-032 Rendering of one entry to a 7-bit mask SHALL be a sub-module seg_pos_decode (inputs row, col, display index, turn flag).

Verification
REQ-033 Reset, release, no strobes -> hex_o display0 = 7'b1111110 (active-low, a lit), other displays 7'h7F, err_o=0.
REQ-034 Strobe with row=1, col=5 at cycle T -> step_o at T+2; from T+3 display5 segment a lit at all pwm_cnt values.
REQ-035 TAIL_LEN=2, TAIL_DUTY=4, positions col 2,1,0 on top row -> display1/display2 segment a lit only while pwm_cnt<4; display0 a always lit.
REQ-036 Positions (row1,col0) then (row0,col0) -> display0 lights a, d, b, c; no verticals on display5.
REQ-037 Strobe with curr_display_i=6 -> no segment lit for that entry, err_o=1 and stays 1 until rst_ni low.
REQ-038 Strobes in two consecutive cycles, then rst_ni low at T+2 -> history reset, hex_o shows only display0 segment a after release.
